// File: rtl/lcd_bus_sequencer_if.sv
// Request handshake and LCD pin bundle for lcd_bus_sequencer.
// LCD_BUSY_POLL_EN adds the data-bus output enable and the busy-flag input.
interface lcd_bus_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  logic       init_done;
`ifdef LCD_BUSY_POLL_EN
  logic       lcd_data_oe;
  logic       lcd_db7_in;

  modport master (
    output req_valid, req_rs, req_data, lcd_db7_in,
    input  req_ready, lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, lcd_data_oe
  );

  modport slave (
    input  req_valid, req_rs, req_data, lcd_db7_in,
    output req_ready, lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, lcd_data_oe
  );
`else
  modport master (
    output req_valid, req_rs, req_data,
    input  req_ready, lcd_rs, lcd_rw, lcd_en, lcd_data, init_done
  );

  modport slave (
    input  req_valid, req_rs, req_data,
    output req_ready, lcd_rs, lcd_rw, lcd_en, lcd_data, init_done
  );
`endif
endinterface

// File: rtl/lcd_bus_sequencer.sv
// HD44780-style parallel bus sequencer: autonomous power-up init, then timed byte writes.
// Define LCD_BUSY_POLL_EN to replace the fixed user-write wait with busy-flag polling.
module lcd_bus_sequencer #(
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000,
  parameter int T_PWR_CYC   = 750000,
  parameter int CNT_W       = 20
) (
  input logic                clk,
  input logic                rst,
  lcd_bus_sequencer_if.slave bus
);

  localparam logic [2:0] PWR_WAIT  = 3'd0;
  localparam logic [2:0] INIT_LOAD = 3'd1;
  localparam logic [2:0] SETUP     = 3'd2;
  localparam logic [2:0] EN_HIGH   = 3'd3;
  localparam logic [2:0] EXEC_WAIT = 3'd4;
  localparam logic [2:0] IDLE      = 3'd5;
`ifdef LCD_BUSY_POLL_EN
  localparam logic [2:0] BF_SETUP  = 3'd6;
  localparam logic [2:0] BF_EN     = 3'd7;
`endif

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(T_PWR_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(T_EN_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(T_CMD_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(T_CLR_CYC - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       init_step;
  logic             rs_q;
  logic             en_q;
  logic             done_q;
  logic [7:0]       data_q;
  logic             cnt_zero;
  logic             long_cmd;
`ifdef LCD_BUSY_POLL_EN
  logic             rw_q;
  logic             oe_q;
  logic [CNT_W-1:0] poll_cnt;
`endif

  function automatic logic [7:0] init_byte(input logic [1:0] step);
    case (step)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  assign cnt_zero = (cnt == '0);
  // Clear (0x01) and return home (0x02/0x03) need the long execution wait.
  assign long_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  // Power-on wait counts up from the cleared reset value; every other phase counts down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      init_step <= 2'd0;
      rs_q      <= 1'b0;
      en_q      <= 1'b0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      rw_q      <= 1'b0;
      oe_q      <= 1'b1;
      poll_cnt  <= '0;
`endif
    end else begin
      case (state)
        PWR_WAIT: begin
          if (cnt == PWR_LAST) begin
            init_step <= 2'd0;
            rs_q      <= 1'b0;
            data_q    <= init_byte(2'd0);
            cnt       <= SETUP_LOAD;
            state     <= SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INIT_LOAD: begin
          rs_q   <= 1'b0;
          data_q <= init_byte(init_step);
          cnt    <= SETUP_LOAD;
          state  <= SETUP;
        end
        IDLE: begin
          if (bus.req_valid) begin
            rs_q   <= bus.req_rs;
            data_q <= bus.req_data;
            cnt    <= SETUP_LOAD;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            en_q  <= 1'b1;
            cnt   <= EN_LOAD;
            state <= EN_HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EN_HIGH: begin
          if (cnt_zero) begin
            en_q <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            if (done_q) begin
              rs_q     <= 1'b0;
              rw_q     <= 1'b1;
              oe_q     <= 1'b0;
              poll_cnt <= '0;
              cnt      <= SETUP_LOAD;
              state    <= BF_SETUP;
            end else begin
              cnt   <= long_cmd ? CLR_LOAD : CMD_LOAD;
              state <= EXEC_WAIT;
            end
`else
            cnt   <= long_cmd ? CLR_LOAD : CMD_LOAD;
            state <= EXEC_WAIT;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EXEC_WAIT: begin
          if (cnt_zero) begin
            if (done_q) begin
              state <= IDLE;
            end else if (init_step == 2'd3) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              init_step <= init_step + 2'd1;
              rs_q      <= 1'b0;
              data_q    <= init_byte(init_step + 2'd1);
              cnt       <= SETUP_LOAD;
              state     <= SETUP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef LCD_BUSY_POLL_EN
        BF_SETUP: begin
          poll_cnt <= poll_cnt + 1'b1;
          if (poll_cnt == CLR_LOAD) begin
            rw_q  <= 1'b0;
            oe_q  <= 1'b1;
            state <= IDLE;
          end else if (cnt_zero) begin
            en_q  <= 1'b1;
            cnt   <= EN_LOAD;
            state <= BF_EN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BF_EN: begin
          poll_cnt <= poll_cnt + 1'b1;
          if ((poll_cnt == CLR_LOAD) || (cnt_zero && !bus.lcd_db7_in)) begin
            en_q  <= 1'b0;
            rw_q  <= 1'b0;
            oe_q  <= 1'b1;
            state <= IDLE;
          end else if (cnt_zero) begin
            en_q  <= 1'b0;
            cnt   <= SETUP_LOAD;
            state <= BF_SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        default: begin
          state     <= PWR_WAIT;
          cnt       <= '0;
          init_step <= 2'd0;
          rs_q      <= 1'b0;
          en_q      <= 1'b0;
          data_q    <= 8'h00;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_en    = en_q;
  assign bus.lcd_data  = data_q;
  assign bus.init_done = done_q;
`ifdef LCD_BUSY_POLL_EN
  assign bus.lcd_rw      = rw_q;
  assign bus.lcd_data_oe = oe_q;
`else
  assign bus.lcd_rw    = 1'b0;
`endif

endmodule
